// File: rtl/time_set_ctrl.sv
// time_set_ctrl: push-button time-setting sequencer for an HH:MM:SS clock.
// Conditions two raw buttons (2-FF sync + debounce + rising-edge press),
// walks RUN -> SET_HOUR -> SET_MIN -> COMMIT, edits a shadow hour/minute and
// issues a one-cycle load strobe so the clock counter restarts at HH:MM:00.
// Optional feature macro: AUTO_REPEAT_EN (hold INC to auto-increment).
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   sec_pulse  1-clk once-per-second strobe
//   btn_mode   raw MODE button (async, active-high)
//   btn_inc    raw INC button (async, active-high)
//   cur_min    live minute (0..59)
//   cur_hour   live hour (0..23)
//   clk_en     clock counter enable, low while editing/committing
//   load       1-clk load strobe for load_hour/load_min, seconds = 0
//   load_min   shadow minute
//   load_hour  shadow hour
//   blink      [1]=blank hour digits, [0]=blank minute digits
//   mode       0=RUN 1=SET_HOUR 2=SET_MIN 3=COMMIT
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_pulse,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hour,
  output logic       clk_en,
  output logic       load,
  output logic [5:0] load_min,
  output logic [4:0] load_hour,
  output logic [1:0] blink,
  output logic [1:0] mode
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned N_BTN   = 2;
  localparam int unsigned MAX_HR  = 23;
  localparam int unsigned MAX_MIN = 59;

  // Parameter sanity: debounce needs at least one sample, repeat delay stays small.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY > 250) begin : g_bad_param
    $error("time_set_ctrl: illegal DEBOUNCE_CYCLES/REPEAT_DELAY");
  end

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_e;

  // Button index 0 = MODE, 1 = INC.
  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] db_q, db_d, db_prev_q;
  logic [DB_W-1:0]  db_cnt_q [N_BTN];
  logic [DB_W-1:0]  db_cnt_d [N_BTN];

  state_e     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic       phase_q, phase_d;
  logic       clk_en_q, clk_en_d;
  logic       load_q, load_d;
  logic [1:0] blink_q, blink_d;

  logic mode_press_c, inc_press_c, repeat_c, inc_evt_c, editing_c;

  // Debounce: flip only after DEBOUNCE_CYCLES consecutive samples differ from the held level.
  always_comb begin
    for (int i = 0; i < int'(N_BTN); i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) db_d[i] = sync2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  assign mode_press_c = db_q[0] & ~db_prev_q[0];
  assign inc_press_c  = db_q[1] & ~db_prev_q[1];
  assign editing_c    = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RP_W = $clog2(REPEAT_DELAY + 2);
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;

  // The first sec_pulse after the press only starts timing (partial second);
  // REPEAT_DELAY full seconds later each sec_pulse acts as an INC press.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    repeat_c  = 1'b0;
    if (!editing_c || !db_q[1] || mode_press_c) begin
      rep_cnt_d = '0;
    end else if (sec_pulse) begin
      if (rep_cnt_q == RP_W'(REPEAT_DELAY + 1)) repeat_c = 1'b1;
      else rep_cnt_d = rep_cnt_q + RP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) rep_cnt_q <= '0;
    else        rep_cnt_q <= rep_cnt_d;
  end
`else
  assign repeat_c = 1'b0;
`endif

  assign inc_evt_c = inc_press_c | repeat_c;

  // FSM next state, shadow edits and registered outputs; MODE beats INC.
  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    min_d    = min_q;
    phase_d  = phase_q;
    clk_en_d = (state_q == ST_RUN);
    load_d   = (state_q == ST_COMMIT);
    blink_d  = 2'b00;

    if (state_q != ST_RUN && sec_pulse) phase_d = ~phase_q;

    case (state_q)
      ST_RUN: begin
        if (mode_press_c) begin
          state_d = ST_SET_HOUR;
          hour_d  = (cur_hour > 5'(MAX_HR))  ? 5'd0 : cur_hour;
          min_d   = (cur_min  > 6'(MAX_MIN)) ? 6'd0 : cur_min;
          phase_d = 1'b0;
        end
      end
      ST_SET_HOUR: begin
        blink_d = {phase_q, 1'b0};
        if (mode_press_c)   state_d = ST_SET_MIN;
        else if (inc_evt_c) hour_d  = (hour_q >= 5'(MAX_HR)) ? 5'd0 : hour_q + 5'd1;
      end
      ST_SET_MIN: begin
        blink_d = {1'b0, phase_q};
        if (mode_press_c)   state_d = ST_COMMIT;
        else if (inc_evt_c) min_d   = (min_q >= 6'(MAX_MIN)) ? 6'd0 : min_q + 6'd1;
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < int'(N_BTN); i++) db_cnt_q[i] <= '0;
      state_q   <= ST_RUN;
      hour_q    <= '0;
      min_q     <= '0;
      phase_q   <= 1'b0;
      clk_en_q  <= 1'b1;
      load_q    <= 1'b0;
      blink_q   <= 2'b00;
    end else begin
      sync1_q   <= {btn_inc, btn_mode};
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < int'(N_BTN); i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      phase_q   <= phase_d;
      clk_en_q  <= clk_en_d;
      load_q    <= load_d;
      blink_q   <= blink_d;
    end
  end

  assign clk_en    = clk_en_q;
  assign load      = load_q;
  assign load_min  = min_q;
  assign load_hour = hour_q;
  assign blink     = blink_q;
  assign mode      = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: randomized self-checking bench for time_set_ctrl against
// an event-level model of the button/FSM rules (DEBOUNCE_CYCLES=4).
module tb_time_set_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sec_pulse = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] cur_min = 6'd45;
  logic [4:0] cur_hour = 5'd13;
  logic       clk_en, load;
  logic [5:0] load_min;
  logic [4:0] load_hour;
  logic [1:0] blink, mode;

  time_set_ctrl #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD)) dut (
    .clk(clk), .reset(reset), .sec_pulse(sec_pulse), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .cur_min(cur_min), .cur_hour(cur_hour), .clk_en(clk_en),
    .load(load), .load_min(load_min), .load_hour(load_hour), .blink(blink), .mode(mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: state 0=RUN 1=SET_HOUR 2=SET_MIN (COMMIT is transient).
  int m_state = 0, m_hour = 0, m_min = 0, m_phase = 0;
  int m_loads = 0, m_last_h = 0, m_last_m = 0;

  // Load strobe observer.
  int   obs_loads = 0, obs_h = 0, obs_m = 0;
  logic prev_load = 1'b0;
  always @(negedge clk) begin
    if (load) begin
      obs_loads++;
      obs_h = int'(load_hour);
      obs_m = int'(load_min);
      chk("load_clk_en_low", 32'(clk_en), 0);
      chk("load_one_cycle", 32'(prev_load), 0);
    end
    prev_load = load;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_mode();
    case (m_state)
      0: begin m_state = 1; m_hour = int'(cur_hour); m_min = int'(cur_min); m_phase = 0; end
      1: m_state = 2;
      default: begin m_state = 0; m_loads++; m_last_h = m_hour; m_last_m = m_min; end
    endcase
  endtask

  task automatic m_inc();
    if (m_state == 1) m_hour = (m_hour == 23) ? 0 : m_hour + 1;
    else if (m_state == 2) m_min = (m_min == 59) ? 0 : m_min + 1;
  endtask

  task automatic press(input bit m, input bit i);
    btn_mode = m; btn_inc = i;
    tick(10);
    btn_mode = 0; btn_inc = 0;
    tick(10);
    if (m) m_mode();
    else if (i) m_inc();
  endtask

  task automatic sec(input int k);
    for (int p = 0; p < k; p++) begin
      sec_pulse = 1; tick(1); sec_pulse = 0; tick(3);
      if (m_state != 0) m_phase ^= 1;
    end
  endtask

  task automatic glitch(input bit which, input int len);
    if (which) btn_inc = 1; else btn_mode = 1;
    tick(len);
    btn_mode = 0; btn_inc = 0;
    tick(10);
  endtask

  task automatic do_reset();
    reset = 0; tick(3); reset = 1; tick(2);
    m_state = 0; m_hour = 0; m_min = 0; m_phase = 0;
  endtask

  task automatic hold_inc(input int pulses);
    int reps;
    btn_inc = 1;
    tick(10);
    m_inc();
    reps = 0;
`ifdef AUTO_REPEAT_EN
    reps = (pulses > int'(RD) + 1) ? pulses - int'(RD) - 1 : 0;
`endif
    sec(pulses);
    for (int r = 0; r < reps; r++) m_inc();
    btn_inc = 0;
    tick(10);
  endtask

  task automatic check_all(input string tag);
    int eb;
    eb = (m_state == 1) ? (m_phase << 1) : (m_state == 2) ? m_phase : 0;
    chk({tag, ".mode"},      32'(mode),      m_state);
    chk({tag, ".clk_en"},    32'(clk_en),    (m_state == 0) ? 1 : 0);
    chk({tag, ".load"},      32'(load),      0);
    chk({tag, ".load_hour"}, 32'(load_hour), m_hour);
    chk({tag, ".load_min"},  32'(load_min),  m_min);
    chk({tag, ".blink"},     32'(blink),     eb);
    chk({tag, ".n_loads"},   obs_loads,      m_loads);
    chk({tag, ".last_load"}, obs_h * 100 + obs_m, m_last_h * 100 + m_last_m);
  endtask

  initial begin
    // Reset held 3 cycles, outputs at reset values, then hold after release.
    reset = 0;
    tick(3);
    check_all("reset");
    reset = 1;
    tick(5);
    check_all("post_reset");

    // Enter edit with live 13:45, then commit unchanged.
    press(1, 0); check_all("enter_1345");
    sec(3);      check_all("blink_hour");
    press(1, 0); check_all("to_set_min");
    sec(1);      check_all("blink_min");
    press(1, 0); check_all("commit_1345");

    // Hour and minute wrap.
    cur_hour = 5'd22; cur_min = 6'd58;
    press(1, 0);
    for (int k = 0; k < 3; k++) begin press(0, 1); check_all("hour_wrap"); end
    press(1, 0);
    for (int k = 0; k < 2; k++) begin press(0, 1); check_all("min_wrap"); end
    press(1, 0); check_all("commit_wrap");

    // INC ignored in RUN; MODE+INC same clock; short glitches.
    press(0, 1); check_all("inc_in_run");
    press(1, 0);
    press(1, 1); check_all("mode_beats_inc");
    glitch(1'b0, 3); glitch(1'b1, 2); check_all("glitch");

    // Reset mid SET_MIN discards shadow without loading.
    press(0, 1);
    do_reset(); check_all("reset_mid_edit");

    // Held INC in SET_MIN from 10.
    cur_hour = 5'd7; cur_min = 6'd10;
    press(1, 0); press(1, 0);
    hold_inc(5); check_all("hold_inc");
    press(1, 0); check_all("commit_hold");

    // Randomized operations.
    for (int it = 0; it < 60; it++) begin
      int op;
      if (m_state == 0) begin
        cur_hour = 5'($urandom_range(0, 23));
        cur_min  = 6'($urandom_range(0, 59));
      end
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1, 2: press(1, 0);
        3, 4, 5: press(0, 1);
        6:       press(1, 1);
        7:       sec(int'($urandom_range(1, 3)));
        8:       glitch(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
        default: if ($urandom_range(0, 3) == 0) do_reset(); else hold_inc(int'($urandom_range(1, 5)));
      endcase
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
